wb_trace_fifo: RTL and testbench

Writeback trace buffer sitting directly downstream of the single-cycle MIPS processor core. Each cycle it samples the core's retiring register-write (destination register, write data, PC), stamps it with a free-running cycle count and queues it in a small FIFO. A debug sink (UART bridge or testbench monitor) drains the FIFO through a valid/ready handshake. Overflow is counted, never stalls the core.

---
 rtl/wb_trace_fifo_if.sv | 41 ++++
 rtl/wb_trace_fifo.sv | 118 +++++++++++
 tb/tb_wb_trace_fifo.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_trace_fifo_if.sv
// ---------------------------------------------------------------------------
// wb_trace_fifo_if
//
// Bundles the two streams that pass through the writeback trace buffer:
//   - the retiring register-write from the processor core
//     (wb_en, wb_reg, wb_data, wb_pc)
//   - the drain handshake toward the debug sink
//     (out_valid/out_ready plus the head entry out_reg, out_data,
//      out_pc, out_stamp)
//
// Modports:
//   slave  : the trace buffer itself (samples wb_*, drives out_*)
//   master : whoever surrounds it (core writeback + sink, or a testbench)
// ---------------------------------------------------------------------------
interface wb_trace_fifo_if #(
   parameter int STAMP_W = 16
);

   logic               wb_en;
   logic [4:0]         wb_reg;
   logic [31:0]        wb_data;
   logic [31:0]        wb_pc;

   logic               out_valid;
   logic               out_ready;
   logic [4:0]         out_reg;
   logic [31:0]        out_data;
   logic [31:0]        out_pc;
   logic [STAMP_W-1:0] out_stamp;

   modport slave (
      input  wb_en, wb_reg, wb_data, wb_pc, out_ready,
      output out_valid, out_reg, out_data, out_pc, out_stamp
   );

   modport master (
      output wb_en, wb_reg, wb_data, wb_pc, out_ready,
      input  out_valid, out_reg, out_data, out_pc, out_stamp
   );

endinterface

// File: rtl/wb_trace_fifo.sv
// ---------------------------------------------------------------------------
// wb_trace_fifo
//
// Writeback trace buffer for the single-cycle MIPS core. Every retiring
// register write (except writes to $zero) is stamped with a free-running
// cycle count and queued. A debug sink drains entries via valid/ready with
// first-word-fall-through outputs. When the queue is full new entries are
// discarded and counted; the core is never stalled.
//
// Ports:
//   CLK     : clock, all state updates on the rising edge
//   RST_N   : asynchronous active-low reset
//   clear   : synchronous flush of queue, drop counter and stamp counter
//   bus     : wb_trace_fifo_if.slave (writeback capture + drain handshake)
//   count   : occupied entries (0..DEPTH)
//   full    : count == DEPTH
//   dropped : saturating count of entries lost to overflow
// ---------------------------------------------------------------------------
module wb_trace_fifo #(
   parameter  int DEPTH   = 16,
   parameter  int STAMP_W = 16,
   localparam int AW      = $clog2(DEPTH),
   localparam int CW      = AW + 1
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 clear,
   wb_trace_fifo_if.slave       bus,
   output logic [CW-1:0]        count,
   output logic                 full,
   output logic [15:0]          dropped
);

   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [4:0]         memReg   [DEPTH];
   logic [31:0]        memData  [DEPTH];
   logic [31:0]        memPc    [DEPTH];
   logic [STAMP_W-1:0] memStamp [DEPTH];

   logic [AW-1:0]      wrPtr;
   logic [AW-1:0]      rdPtr;
   logic [STAMP_W-1:0] stamp;

   logic pushReq;
   logic pop;
   logic isFull;
   logic doWrite;

   // A capture request is any register write that does not target $zero.
   // A pop happens only when there is something to hand out. When full, a
   // write is still accepted if a pop frees the head slot in the same cycle;
   // otherwise the request becomes a drop. clear wins over everything.
   always_comb begin
      pushReq = bus.wb_en && (bus.wb_reg != 5'd0);
      isFull  = (count == FULL_COUNT);
      pop     = (count != '0) && bus.out_ready;
      doWrite = pushReq && (!isFull || pop) && !clear;
   end

   // Pointer, occupancy, drop and stamp bookkeeping. Reset and clear both
   // return everything to zero; the storage array itself is left alone since
   // its contents are meaningless once the pointers are zeroed.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wrPtr   <= '0;
         rdPtr   <= '0;
         count   <= '0;
         dropped <= '0;
         stamp   <= '0;
      end else if (clear) begin
         wrPtr   <= '0;
         rdPtr   <= '0;
         count   <= '0;
         dropped <= '0;
         stamp   <= '0;
      end else begin
         stamp <= stamp + STAMP_W'(1);
         if (doWrite) begin
            wrPtr <= wrPtr + AW'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + AW'(1);
         end
         case ({doWrite, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (pushReq && isFull && !pop && (dropped != 16'hFFFF)) begin
            dropped <= dropped + 16'd1;
         end
      end
   end

   // Entry storage: written at the write pointer with the stamp value that
   // is current during the capturing cycle. Not reset on purpose.
   always_ff @(posedge CLK) begin
      if (doWrite) begin
         memReg[wrPtr]   <= bus.wb_reg;
         memData[wrPtr]  <= bus.wb_data;
         memPc[wrPtr]    <= bus.wb_pc;
         memStamp[wrPtr] <= stamp;
      end
   end

   // First-word-fall-through: the head entry is always presented, and valid
   // simply reflects a non-empty queue.
   always_comb begin
      bus.out_valid = (count != '0);
      bus.out_reg   = memReg[rdPtr];
      bus.out_data  = memData[rdPtr];
      bus.out_pc    = memPc[rdPtr];
      bus.out_stamp = memStamp[rdPtr];
      full          = isFull;
   end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// ---------------------------------------------------------------------------
// tb_wb_trace_fifo
//
// Directed-vector bench for wb_trace_fifo. Stimulus issues writeback
// vectors and pushes the entries the buffer should accept into a queue;
// a separate monitor compares every entry the DUT hands out on a completed
// handshake, plus occupancy, full and drop counter each cycle.
// ---------------------------------------------------------------------------
module tb_wb_trace_fifo;

   localparam int DEPTH   = 16;
   localparam int STAMP_W = 16;

   typedef struct {
      logic [4:0]         r;
      logic [31:0]        d;
      logic [31:0]        p;
      logic [STAMP_W-1:0] s;
   } entry_t;

   logic               CLK   = 1'b0;
   logic               RST_N = 1'b0;
   logic               clear = 1'b0;
   logic [4:0]         count;
   logic               full;
   logic [15:0]        dropped;

   entry_t             sbQueue [$];
   entry_t             monEntry;
   logic [15:0]        dropModel = 16'd0;
   logic [STAMP_W-1:0] stampModel;

   int nChecks = 0;
   int nFails  = 0;

   wb_trace_fifo_if #(.STAMP_W(STAMP_W)) bus ();

   wb_trace_fifo #(
      .DEPTH   (DEPTH),
      .STAMP_W (STAMP_W)
   ) dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .clear   (clear),
      .bus     (bus.slave),
      .count   (count),
      .full    (full),
      .dropped (dropped)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 CLK = ~CLK;

   // Reference stamp counter: zero under reset or clear, +1 each edge.
   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stampModel <= '0;
      end else if (clear) begin
         stampModel <= '0;
      end else begin
         stampModel <= stampModel + 16'd1;
      end
   end

   // One comparison: bump the counters and report a mismatch.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive one cycle of inputs (called just after a rising edge), let the
   // edge happen, return inputs to idle and update the expected queue with
   // the entry that edge should have captured.
   task automatic applyStimulus(input bit en, input logic [4:0] r,
                                input logic [31:0] d, input logic [31:0] p,
                                input bit rdy, input bit clr);
      int     sz;
      bit     popWill;
      bit     pushReq;
      entry_t e;
      bus.wb_en     = en;
      bus.wb_reg    = r;
      bus.wb_data   = d;
      bus.wb_pc     = p;
      bus.out_ready = rdy;
      clear         = clr;
      sz      = sbQueue.size();
      popWill = (sz != 0) && rdy;
      pushReq = en && (r != 5'd0);
      e.r = r;
      e.d = d;
      e.p = p;
      e.s = stampModel;
      @(posedge CLK);
      #1;
      bus.wb_en     = 1'b0;
      bus.out_ready = 1'b0;
      clear         = 1'b0;
      if (clr) begin
         sbQueue.delete();
         dropModel = 16'd0;
      end else if (pushReq) begin
         if ((sz < DEPTH) || popWill) begin
            sbQueue.push_back(e);
         end else if (dropModel != 16'hFFFF) begin
            dropModel = dropModel + 16'd1;
         end
      end
   endtask

   // Monitor: mid-cycle, compare status against the scoreboard and, when a
   // handshake is about to complete, pop and compare the head entry.
   always @(negedge CLK) begin
      if (RST_N) begin
         checkOutput("mon count", count, sbQueue.size());
         checkOutput("mon out_valid", bus.out_valid, sbQueue.size() != 0);
         checkOutput("mon full", full, sbQueue.size() == DEPTH);
         checkOutput("mon dropped", dropped, dropModel);
         if (bus.out_valid && bus.out_ready) begin
            if (sbQueue.size() == 0) begin
               checkOutput("mon unexpected entry", 1, 0);
            end else begin
               monEntry = sbQueue.pop_front();
               checkOutput("mon out_reg", bus.out_reg, monEntry.r);
               checkOutput("mon out_data", bus.out_data, monEntry.d);
               checkOutput("mon out_pc", bus.out_pc, monEntry.p);
               checkOutput("mon out_stamp", bus.out_stamp, monEntry.s);
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.wb_en     = 1'b0;
      bus.wb_reg    = 5'd0;
      bus.wb_data   = 32'd0;
      bus.wb_pc     = 32'd0;
      bus.out_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge CLK);
      #1;
      checkOutput("reset out_valid", bus.out_valid, 0);
      checkOutput("reset count", count, 0);
      checkOutput("reset full", full, 0);
      checkOutput("reset dropped", dropped, 0);
      RST_N = 1'b1;
      @(posedge CLK);
      #1;

      // Single push then single pop
      $display("[TB] single push/pop");
      applyStimulus(1'b1, 5'd8, 32'h0000_0005, 32'h3, 1'b0, 1'b0);
      @(negedge CLK);
      checkOutput("single out_valid", bus.out_valid, 1);
      checkOutput("single out_reg", bus.out_reg, 8);
      checkOutput("single out_data", bus.out_data, 5);
      checkOutput("single out_pc", bus.out_pc, 3);
      checkOutput("single out_stamp", bus.out_stamp, 1);
      checkOutput("single count", count, 1);
      @(posedge CLK);
      #1;
      applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      @(negedge CLK);
      checkOutput("after pop out_valid", bus.out_valid, 0);
      checkOutput("after pop count", count, 0);
      @(posedge CLK);
      #1;

      // Writes to $zero are never queued
      $display("[TB] zero-register filter");
      repeat (5) applyStimulus(1'b1, 5'd0, 32'hDEAD_BEEF, 32'h40, 1'b0, 1'b0);
      @(negedge CLK);
      checkOutput("zero count", count, 0);
      checkOutput("zero dropped", dropped, 0);
      @(posedge CLK);
      #1;

      // Overflow: 20 pushes into 16 entries
      $display("[TB] overflow");
      for (int i = 1; i <= 20; i++) begin
         applyStimulus(1'b1, 5'd9, 32'(i), 32'h1000 + 32'(4 * i), 1'b0, 1'b0);
      end
      @(negedge CLK);
      checkOutput("ovf full", full, 1);
      checkOutput("ovf count", count, 16);
      checkOutput("ovf dropped", dropped, 4);
      @(posedge CLK);
      #1;
      repeat (16) applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      @(negedge CLK);
      checkOutput("ovf drained count", count, 0);
      checkOutput("ovf dropped held", dropped, 4);
      @(posedge CLK);
      #1;
      applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1);

      // Full with simultaneous push and pop
      $display("[TB] full push+pop");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 5'd10, 32'h100 + 32'(i), 32'h2000 + 32'(4 * i), 1'b0, 1'b0);
      end
      applyStimulus(1'b1, 5'd10, 32'hAA, 32'h2100, 1'b1, 1'b0);
      @(negedge CLK);
      checkOutput("fullpp count", count, 16);
      checkOutput("fullpp dropped", dropped, 0);
      checkOutput("fullpp full", full, 1);
      @(posedge CLK);
      #1;
      repeat (16) applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);

      // Pointer wrap with shallow occupancy
      $display("[TB] pointer wrap");
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'b1, 5'(1 + (i % 31)), 32'h5000 + 32'(i),
                       32'h4000 + 32'(4 * i), (i >= 2), 1'b0);
      end
      repeat (2) applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      @(negedge CLK);
      checkOutput("wrap count", count, 0);
      checkOutput("wrap dropped", dropped, 0);
      @(posedge CLK);
      #1;

      // clear overrides a same-cycle push; stamps restart
      $display("[TB] clear");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 5'd11, 32'h60 + 32'(i), 32'h6000 + 32'(4 * i), 1'b0, 1'b0);
      end
      applyStimulus(1'b1, 5'd12, 32'h77, 32'h3000, 1'b0, 1'b1);
      @(negedge CLK);
      checkOutput("clear count", count, 0);
      checkOutput("clear out_valid", bus.out_valid, 0);
      checkOutput("clear dropped", dropped, 0);
      @(posedge CLK);
      #1;
      applyStimulus(1'b1, 5'd13, 32'h88, 32'h3004, 1'b0, 1'b0);
      @(negedge CLK);
      checkOutput("post-clear out_stamp", bus.out_stamp, 1);
      checkOutput("post-clear out_data", bus.out_data, 32'h88);
      @(posedge CLK);
      #1;
      applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);

      // Asynchronous reset between edges
      $display("[TB] async reset");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 5'd14, 32'h90 + 32'(i), 32'h7000 + 32'(4 * i), 1'b0, 1'b0);
      end
      @(posedge CLK);
      #3;
      RST_N = 1'b0;
      #1;
      checkOutput("async out_valid", bus.out_valid, 0);
      checkOutput("async count", count, 0);
      checkOutput("async full", full, 0);
      checkOutput("async dropped", dropped, 0);
      sbQueue.delete();
      dropModel = 16'd0;
      #2;
      RST_N = 1'b1;
      repeat (3) @(posedge CLK);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
